// File: rtl/pid_pkg.sv
// Shared types, default coefficients and helpers for the PID steering
// controller (pid_ctrl_param) and its saturator (pid_sat).
//   pid_state_t : forward-speed ramp FSM encoding (IDLE=0, RAMP=1, RUN=2)
//   PID_*       : default parameter values for pid_ctrl_param
//   sat_s()     : clamp a 32-bit signed value into a signed field of 'width' bits
package pid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } pid_state_t;

    localparam int PID_ERR_W       = 16;
    localparam int PID_SAT_W       = 11;
    localparam int PID_DSAT_W      = 8;
    localparam int PID_PID_W       = 15;
    localparam int PID_SPD_W       = 12;
    localparam int PID_P_COEFF     = 6;
    localparam int PID_D_COEFF     = 56;
    localparam int PID_I_SHIFT     = 6;
    localparam int PID_RAMP_STEP   = 4;
    localparam int PID_RAMP_MAX    = 768;
    localparam int PID_MOVE_THRESH = 128;
    localparam int PID_ACC_W       = 16;

    function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                                 input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Parametrised signed saturator: clamps a two's-complement IN_W-bit value
// into OUT_W bits (IN_W > OUT_W). Purely combinational.
//   din_i  [IN_W]  : signed input
//   dout_o [OUT_W] : signed saturated output
module pid_sat
    import pid_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 11
) (
    input  logic [IN_W-1:0]  din_i,
    output logic [OUT_W-1:0] dout_o
);

    localparam int TOP_W = IN_W - OUT_W + 1;

    // The value fits when every bit from the sign down to the output's sign
    // bit agrees.
    logic [TOP_W-1:0] top;
    assign top = din_i[IN_W-1:OUT_W-1];

    always_comb begin
        if (top == '0 || top == '1) begin
            dout_o = din_i[OUT_W-1:0];
        end else if (din_i[IN_W-1]) begin
            dout_o = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout_o = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pid_ctrl_param.sv
// Pipelined PID steering controller for the line-following drive path.
// Three register stages: S0 saturates the error, S1 forms P/D terms and
// updates the integrator, S2 sums, saturates and mixes into wheel speeds.
// A forward-speed ramp FSM (IDLE/RAMP/RUN) supplies FRWRD.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   go                : run enable; low forces IDLE and clears FRWRD/accum
//   err_vld           : error sample valid
//   line_present      : vehicle over line; a rising edge clears the integrator
//   error [ERR_W]     : signed steering error
//   lft_spd [SPD_W]   : left wheel speed (held between strobes)
//   rght_spd [SPD_W]  : right wheel speed (held between strobes)
//   out_vld           : one-cycle strobe, speeds updated (err_vld + 3 cycles)
//   moving            : FRWRD > MOVE_THRESH
//   state [2]         : FSM state (IDLE=0, RAMP=1, RUN=2)
//
// Build option: define PID_SPD_CLAMP_EN to clamp speeds to [0, 2^SPD_W-1];
// otherwise speeds wrap modulo 2^SPD_W.
module pid_ctrl_param
    import pid_pkg::*;
#(
    parameter int ERR_W       = PID_ERR_W,
    parameter int SAT_W       = PID_SAT_W,
    parameter int DSAT_W      = PID_DSAT_W,
    parameter int PID_W       = PID_PID_W,
    parameter int SPD_W       = PID_SPD_W,
    parameter int P_COEFF     = PID_P_COEFF,
    parameter int D_COEFF     = PID_D_COEFF,
    parameter int I_SHIFT     = PID_I_SHIFT,
    parameter int RAMP_STEP   = PID_RAMP_STEP,
    parameter int RAMP_MAX    = PID_RAMP_MAX,
    parameter int MOVE_THRESH = PID_MOVE_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             err_vld,
    input  logic             line_present,
    input  logic [ERR_W-1:0] error,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             out_vld,
    output logic             moving,
    output logic [1:0]       state
);

    localparam int DIFF_W = SAT_W + 1;
    localparam int ASUM_W = PID_ACC_W + 1;
    localparam int SUM_W  = PID_W + 1;

    // ------------------------------------------------------------------
    // Ramp FSM
    // ------------------------------------------------------------------
    pid_state_t       state_q, state_d;
    logic [SPD_W-1:0] frwrd_q, frwrd_d;
    logic [SPD_W:0]   frwrd_inc;
    logic             moving_w;

    assign frwrd_inc = {1'b0, frwrd_q} + (SPD_W+1)'(RAMP_STEP);
    assign moving_w  = frwrd_q > SPD_W'(MOVE_THRESH);

    always_comb begin
        state_d = state_q;
        frwrd_d = frwrd_q;
        if (!go) begin
            state_d = IDLE;
            frwrd_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frwrd_d = '0;
                    state_d = RAMP;
                end
                RAMP: begin
                    if (err_vld) begin
                        if (frwrd_inc >= (SPD_W+1)'(RAMP_MAX)) begin
                            frwrd_d = SPD_W'(RAMP_MAX);
                            state_d = RUN;
                        end else begin
                            frwrd_d = frwrd_inc[SPD_W-1:0];
                        end
                    end
                end
                RUN: begin
                    frwrd_d = SPD_W'(RAMP_MAX);
                end
                default: begin
                    state_d = IDLE;
                    frwrd_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frwrd_q <= '0;
        end else begin
            state_q <= state_d;
            frwrd_q <= frwrd_d;
        end
    end

    // ------------------------------------------------------------------
    // S0: input saturation
    // ------------------------------------------------------------------
    logic signed [SAT_W-1:0] err_sat_d, err_sat_q;
    logic                    vld0_q;

    pid_sat #(.IN_W(ERR_W), .OUT_W(SAT_W)) u_sat_err (
        .din_i  (error),
        .dout_o (err_sat_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sat_q <= '0;
            vld0_q    <= 1'b0;
        end else begin
            err_sat_q <= err_sat_d;
            vld0_q    <= err_vld;
        end
    end

    // ------------------------------------------------------------------
    // S1: P and D terms, two-sample history, integrator
    // ------------------------------------------------------------------
    logic signed [SAT_W-1:0]     hist1_q, hist2_q;
    logic signed [DIFF_W-1:0]    ddiff;
    logic signed [DSAT_W-1:0]    dsat;
    logic signed [PID_W-1:0]     p_d, d_d, p1_q, d1_q;
    logic signed [PID_ACC_W-1:0] accum_q, accum_d;
    logic signed [ASUM_W-1:0]    acc_sum;
    logic                        acc_ovf, acc_clr;
    logic                        line_q;
    logic                        vld1_q;

    assign ddiff = DIFF_W'(err_sat_q) - DIFF_W'(hist2_q);

    pid_sat #(.IN_W(DIFF_W), .OUT_W(DSAT_W)) u_sat_d (
        .din_i  (ddiff),
        .dout_o (dsat)
    );

    assign p_d = PID_W'(sat_s(32'(err_sat_q) * P_COEFF, PID_W));
    assign d_d = PID_W'(sat_s(32'(dsat) * D_COEFF, PID_W));

    assign acc_sum = ASUM_W'(accum_q) + ASUM_W'(err_sat_q);
    assign acc_ovf = acc_sum[ASUM_W-1] ^ acc_sum[ASUM_W-2];
    // !go is included so the integrator clears on the same edge as FRWRD.
    assign acc_clr = !go || (state_q == IDLE) || !moving_w || (line_present && !line_q);

    always_comb begin
        accum_d = accum_q;
        if (acc_clr) begin
            accum_d = '0;
        end else if (vld0_q && !acc_ovf) begin
            accum_d = acc_sum[PID_ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q    <= '0;
            d1_q    <= '0;
            hist1_q <= '0;
            hist2_q <= '0;
            accum_q <= '0;
            line_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            vld1_q  <= vld0_q;
            line_q  <= line_present;
            accum_q <= accum_d;
            if (vld0_q) begin
                p1_q    <= p_d;
                d1_q    <= d_d;
                hist1_q <= err_sat_q;
                hist2_q <= hist1_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: sum, saturate, mix with FRWRD
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0] sum_w;
    logic signed [PID_W-1:0] sum_sat, steer, steer_sh;
    logic [SPD_W-1:0]        lft_d, rght_d, lft_q, rght_q;
    logic                    out_vld_q;

    // I is taken from the integrator after this sample's update.
    assign sum_w = SUM_W'(32'(p1_q) + (32'(accum_q) >>> I_SHIFT) + 32'(d1_q));

    pid_sat #(.IN_W(SUM_W), .OUT_W(PID_W)) u_sat_sum (
        .din_i  (sum_w),
        .dout_o (sum_sat)
    );

    assign steer    = moving_w ? sum_sat : '0;
    assign steer_sh = steer >>> 3;

`ifdef PID_SPD_CLAMP_EN
    logic signed [SPD_W+1:0] frwrd_x, sh_x, lft_x, rght_x;

    function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [SPD_W+1:0] v);
        if (v < 0) return '0;
        if (v[SPD_W]) return '1;
        return v[SPD_W-1:0];
    endfunction

    assign frwrd_x = (SPD_W+2)'(frwrd_q);
    assign sh_x    = (SPD_W+2)'(steer_sh);
    assign lft_x   = frwrd_x + sh_x;
    assign rght_x  = frwrd_x - sh_x;
    assign lft_d   = clamp_spd(lft_x);
    assign rght_d  = clamp_spd(rght_x);
`else
    // Modulo wrap: the low SPD_W bits of the wide sum equal an SPD_W-bit sum.
    assign lft_d  = frwrd_q + SPD_W'(steer_sh);
    assign rght_d = frwrd_q - SPD_W'(steer_sh);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q     <= '0;
            rght_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= vld1_q;
            if (vld1_q) begin
                lft_q  <= lft_d;
                rght_q <= rght_d;
            end
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign out_vld  = out_vld_q;
    assign moving   = moving_w;
    assign state    = state_q;

endmodule

// File: tb/tb_pid_ctrl_param.sv
module tb_pid_ctrl_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        err_vld;
    logic        line_present;
    logic [15:0] error;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        out_vld;
    logic        moving;
    logic [1:0]  state;

    pid_ctrl_param dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .err_vld      (err_vld),
        .line_present (line_present),
        .error        (error),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .out_vld      (out_vld),
        .moving       (moving),
        .state        (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int lft;
        int rght;
        int cyc;
        int id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_sent = 0;
    int   last_l = 0;
    int   last_r = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected wheel speed from a signed intermediate value.
    function automatic int spd(input int v);
`ifdef PID_SPD_CLAMP_EN
        if (v < 0) return 0;
        if (v > 4095) return 4095;
        return v;
`else
        return v & 4095;
`endif
    endfunction

    // Expected output for a sample issued this cycle; sum is the hand-derived
    // P+I+D (0 when not moving), frwrd the FRWRD seen by the mixing stage.
    task automatic push(input int frwrd, input int sum);
        exp_t e;
        int   sh;
        sh     = sum >>> 3;
        e.lft  = spd(frwrd + sh);
        e.rght = spd(frwrd - sh);
        e.cyc  = cyc + 3;
        e.id   = n_sent;
        n_sent++;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] e, input int frwrd, input int sum);
        err_vld = 1'b1;
        error   = e;
        push(frwrd, sum);
        tick();
        err_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        sb.delete();
        last_l       = 0;
        last_r       = 0;
        go           = 1'b0;
        err_vld      = 1'b0;
        line_present = 1'b0;
        error        = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic ramp(input int n, input bit chk);
        for (int k = 1; k <= n; k++) begin
            send(16'h0000, (4 * k > 768) ? 768 : 4 * k, 0);
            if (chk) begin
                if (k == 32)  check("moving_after_32", int'(moving), 0);
                if (k == 33)  check("moving_after_33", int'(moving), 1);
                if (k == 191) check("state_after_191", int'(state), 1);
                if (k == 192) check("state_after_192", int'(state), 2);
            end
            repeat (3) tick();
        end
    endtask

    // Monitor: pops an expectation on every strobe, otherwise checks hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_vld) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out_vld: got out_vld=1, expected no output (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("lft#%0d", e.id), int'(lft_spd), e.lft);
                    check($sformatf("rght#%0d", e.id), int'(rght_spd), e.rght);
                    check($sformatf("latency#%0d", e.id), cyc, e.cyc);
                    last_l = e.lft;
                    last_r = e.rght;
                end
            end else begin
                check("hold_lft", int'(lft_spd), last_l);
                check("hold_rght", int'(rght_spd), last_r);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        go           = 1'b0;
        err_vld      = 1'b0;
        line_present = 1'b0;
        error        = '0;
        repeat (2) tick();
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_out_vld", int'(out_vld), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_state", int'(state), 0);
        rst_n = 1'b1;
        tick();

        // Ramp to RUN, then one steer sample: P=48, D=448, I=0 -> 830/706.
        go = 1'b1;
        tick();
        check("state_ramp_entry", int'(state), 1);
        ramp(192, 1'b1);
        send(16'h0008, 768, 496);
        repeat (4) tick();

        // Input saturation: +1023 (sum 13265), then -1024 (P=-6144,
        // D=-7168, I=-1 -> -13313).
        do_reset();
        go = 1'b1;
        tick();
        ramp(192, 1'b0);
        send(16'h7FFF, 768, 13265);
        repeat (3) tick();
        send(16'h8000, 768, -13313);
        repeat (4) tick();

        // Integrator: +1023 held in RUN.
        do_reset();
        go = 1'b1;
        tick();
        ramp(192, 1'b0);
        send(16'h03FF, 768, 13265);          // accum 1023, I=15, D=7112
        repeat (3) tick();
        send(16'h03FF, 768, 13281);          // accum 2046, I=31, D=7112
        repeat (3) tick();
        send(16'h03FF, 768, 6185);           // accum 3069, I=47, D=0
        repeat (3) tick();
        send(16'h03FF, 768, 6201);           // accum 4092, I=63
        repeat (3) tick();
        send(16'h03FF, 768, 6138);           // line rise with the add: accum 0
        line_present = 1'b1;
        repeat (3) tick();
        for (int j = 1; j <= 36; j++) begin
            int a;
            a = 1023 * j;
            if (a > 32767) a = 32736;        // overflowing add holds the value
            send(16'h03FF, 768, 6138 + (a >>> 6));
            repeat (3) tick();
        end

        // Asynchronous reset with a sample in flight.
        send(16'h03FF, 768, 6649);
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_l = 0;
        last_r = 0;
        #1;
        check("async_rst_lft", int'(lft_spd), 0);
        check("async_rst_rght", int'(rght_spd), 0);
        check("async_rst_out_vld", int'(out_vld), 0);
        check("async_rst_moving", int'(moving), 0);
        check("async_rst_state", int'(state), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();

        // Abort mid-ramp: go falls with err_vld; abort wins, FRWRD=0.
        do_reset();
        go = 1'b1;
        tick();
        ramp(40, 1'b0);
        check("pre_abort_moving", int'(moving), 1);
        err_vld = 1'b1;
        error   = 16'h0000;
        go      = 1'b0;
        push(0, 0);
        tick();
        err_vld = 1'b0;
        check("abort_state", int'(state), 0);
        check("abort_moving", int'(moving), 0);
        repeat (3) tick();
        go = 1'b1;
        tick();
        check("reramp_state", int'(state), 1);
        send(16'd100, 4, 0);
        repeat (4) tick();

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d outputs outstanding, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pid_ctrl_param.md
Name: pid_ctrl_param

Overview:
Parametrised, pipelined PID steering controller for the line-following drive path. It sits between the IR error calculator and the motor PWM drivers.
- Saturates the signed error and forms P, I and D terms.
- Runs a forward-speed ramp FSM (IDLE/RAMP/RUN).
- Produces registered left/right wheel speeds with an output valid strobe.
- Improves on the previous fixed-width controller: all widths and coefficients are parameters, the pipeline is 3-stage with a valid strobe, the PID sum is saturated, and the FSM is explicit.

Parameters:
- ERR_W, 16, width of raw signed error input
- SAT_W, 11, width of saturated error
- DSAT_W, 8, width of saturated D difference
- PID_W, 15, width of saturated PID sum
- SPD_W, 12, width of unsigned speed outputs
- P_COEFF, 6, signed P multiplier
- D_COEFF, 56, signed D multiplier
- I_SHIFT, 6, accumulator right-shift producing I term
- RAMP_STEP, 4, FRWRD increment per err_vld while ramping
- RAMP_MAX, 768, FRWRD value at which ramping stops
- MOVE_THRESH, 128, FRWRD must exceed this for steering to apply

Ports:
- clk, input, 1, clock
- rst_n, input, 1, reset
- go, input, 1, run enable; low forces IDLE
- err_vld, input, 1, error sample valid
- line_present, input, 1, vehicle over line
- error, input, ERR_W, signed steering error
- lft_spd, output, SPD_W, left wheel speed
- rght_spd, output, SPD_W, right wheel speed
- out_vld, output, 1, one-cycle strobe: speeds updated
- moving, output, 1, FRWRD > MOVE_THRESH
- state, output, 2, FSM state (IDLE=0, RAMP=1, RUN=2)

Behaviour:
- Reset rst_n: asynchronous, active-low. Clock clk, all flops rising edge.
- Reset values: all outputs 0; FSM in IDLE; FRWRD, accumulator, history and line flops all 0.
- S0 (registered): err_sat = error clamped to [-2^(SAT_W-1), 2^(SAT_W-1)-1]. vld0 = err_vld.
- S1 (registered), using S0 values:
  - P = err_sat*P_COEFF, saturated to PID_W.
  - D: D = sat_DSAT_W(err_sat - hist2)*D_COEFF. hist1/hist2 shift only when vld0 (two-sample lag).
  - I: accum is 16-bit signed and adds sign-extended err_sat only when vld0 and no overflow. On overflow it holds its value. I = accum >>> I_SHIFT.
  - accum clears synchronously when any of these holds: FSM is IDLE, !moving, or rising edge of line_present (line_d tracks line_present, flop reset 0).
- S2 (registered):
  - sum = P + I + D, computed one bit wider than PID_W, then saturated to PID_W.
  - If !moving, sum is forced to 0.
  - lft = FRWRD + (sum>>>3); rght = FRWRD - (sum>>>3), both computed at SPD_W+2 signed.
  - out_vld = vld1.
- Latency: err_vld in cycle N gives out_vld in cycle N+3. Speeds hold their value between strobes.
- FSM (advances only on err_vld, except the go=0 abort):
  - IDLE: FRWRD = 0. go=1 goes to RAMP.
  - RAMP: FRWRD += RAMP_STEP per err_vld. When FRWRD+RAMP_STEP >= RAMP_MAX, load RAMP_MAX and go to RUN.
  - RUN: FRWRD holds at RAMP_MAX.
  - go=0 in any state: next cycle IDLE, FRWRD = 0, accum = 0. Pipeline contents already in flight still complete.
- Simultaneous events: go falling and err_vld in the same cycle → the abort wins. A line_present rise in the same cycle as vld0 → clear wins over add.
- Reset mid-operation: immediate return to reset values; no out_vld until a new err_vld arrives.

Optional Feature:
- Macro: PID_SPD_CLAMP_EN.
- Defined: lft/rght are clamped to [0, 2^SPD_W-1].
- Undefined: lft/rght are truncated to the low SPD_W bits (modulo wrap), matching the legacy behaviour.

Decomposition:
- Package pid_pkg holds:
  - typedef enum logic [1:0] {IDLE, RAMP, RUN} pid_state_t;
  - generic saturate function sat_s(value, width);
  - default coefficient localparams.
- One sub-module, pid_sat, is natural: a parametrised signed saturator (IN_W → OUT_W), instanced for the err, D-diff and PID-sum saturations.

Test Plan:
- Ramp: go=1, error=0, err_vld every 4 clocks.
  - moving rises after the 33rd err_vld (FRWRD=132).
  - state=RUN after the 192nd err_vld.
  - lft=rght=768.
- Steady steer: in RUN with hist=0, one err_vld with error=+8 at cycle N.
  - out_vld at N+3.
  - lft=830, rght=706 (P=48, D=448, I=0).
- Input saturation: error=16'h7FFF, then 16'h8000.
  - err_sat=1023, then -1024.
  - First sample: sum=13265, lft=2426.
- Clamp: first sample of the saturation case.
  - rght=0 with PID_SPD_CLAMP_EN.
  - rght=3206 without it.
- Abort/reset: drop go mid-RAMP.
  - Next cycle state=IDLE and FRWRD=0; accum cleared.
  - Assert rst_n low mid-pipeline → all outputs 0 asynchronously.
- Integrator: hold error=+1023 in RUN and pulse line_present 0→1.
  - accum clears on the rise.
  - Separately, preload accum near 32767 → accum holds its value (no wrap).
